// File: rtl/jk_excite_seq.sv
// JK bank excitation driver: one-cycle J/K pulse per accepted target; optional CHECK stage under JK_SEQ_CHECK_EN.
// Accept->J/K next cycle, done 2 (no check) or 3 (check) edges later; in_ready low while busy, source must hold.
module jk_excite_seq #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t state;

`ifdef JK_SEQ_CHECK_EN
  logic [WIDTH-1:0] target;
`else
  assign mismatch = 1'b0;
  assign err_cnt  = '0;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      j_out <= '0;
      k_out <= '0;
      done  <= 1'b0;
`ifdef JK_SEQ_CHECK_EN
      target   <= '0;
      mismatch <= 1'b0;
      err_cnt  <= '0;
`endif
    end else begin
      done <= 1'b0;
`ifdef JK_SEQ_CHECK_EN
      mismatch <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
`ifdef JK_SEQ_CHECK_EN
            target <= in_data;
`endif
            // set only bits rising, reset only bits falling; never toggle
            j_out <= ~q_in & in_data;
            k_out <= q_in & ~in_data;
            state <= DRIVE;
          end
        end
        DRIVE: begin
          j_out <= '0;
          k_out <= '0;
`ifdef JK_SEQ_CHECK_EN
          state <= CHECK;
`else
          state <= IDLE;
          done  <= 1'b1;
`endif
        end
        CHECK: begin
`ifdef JK_SEQ_CHECK_EN
          done <= 1'b1;
          if (q_in != target) begin
            mismatch <= 1'b1;
            if (err_cnt != {CNT_W{1'b1}})
              err_cnt <= err_cnt + 1'b1;
          end
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_excite_seq.sv
// Directed bench for jk_excite_seq with a JK bank model (optional stuck bits) in the feedback path.
module tb_jk_excite_seq;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] q_in;
  logic [3:0] j_out;
  logic [3:0] k_out;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic [1:0] err_cnt;

  logic [3:0] bank_q;
  logic [3:0] stuck;
  logic       bank_clr;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef JK_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  jk_excite_seq #(.WIDTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .q_in(q_in), .j_out(j_out), .k_out(k_out),
    .busy(busy), .done(done), .mismatch(mismatch), .err_cnt(err_cnt)
  );

  // bank model: Q+ = J&~Q | ~K&Q; stuck bits read back as 0
  always @(posedge clk) begin
    if (bank_clr) bank_q <= 4'b0000;
    else          bank_q <= (j_out & ~bank_q) | (~k_out & bank_q);
  end
  assign q_in = bank_q & ~stuck;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_bank();
    bank_clr = 1'b1;
    step();
    bank_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bank_clr = 1'b1; in_valid = 1'b0; in_data = 4'b0000; stuck = 4'b0000;
    step(); step();
    rst_n = 1'b1; bank_clr = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (j_out !== 4'b0000 || k_out !== 4'b0000) begin n_fail++; $display("FAIL reset_jk got %b/%b want 0000/0000", j_out, k_out); end
    n_cmp++; if (done !== 1'b0 || mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b/%b want 0/0", done, mismatch); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
  endtask

  task automatic test_excite();
    logic [3:0] tv_t [3] = '{4'b1010, 4'b1100, 4'b0110};
    logic [3:0] tv_j [3] = '{4'b1010, 4'b0100, 4'b0010};
    logic [3:0] tv_k [3] = '{4'b0000, 4'b0010, 4'b1000};
    for (int i = 0; i < 3; i++) begin
      in_data = tv_t[i]; in_valid = 1'b1;
      step();
      in_valid = 1'b0; in_data = 4'b1111;
      n_cmp++; if (j_out !== tv_j[i] || k_out !== tv_k[i]) begin n_fail++; $display("FAIL excite%0d_jk got %b/%b want %b/%b", i, j_out, k_out, tv_j[i], tv_k[i]); end
      n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL excite%0d_busy got busy=%b rdy=%b done=%b want 1/0/0", i, busy, in_ready, done); end
      step();
      n_cmp++; if (j_out !== 4'b0000 || k_out !== 4'b0000) begin n_fail++; $display("FAIL excite%0d_jk_clear got %b/%b want 0000/0000", i, j_out, k_out); end
      n_cmp++; if (q_in !== tv_t[i]) begin n_fail++; $display("FAIL excite%0d_bank got %b want %b", i, q_in, tv_t[i]); end
      if (CHK) begin
        n_cmp++; if (done !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL excite%0d_check_state got done=%b busy=%b want 0/1", i, done, busy); end
        step();
      end
      n_cmp++; if (done !== 1'b1 || mismatch !== 1'b0) begin n_fail++; $display("FAIL excite%0d_done got %b/%b want 1/0", i, done, mismatch); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL excite%0d_ready got %b want 1", i, in_ready); end
      step();
      n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL excite%0d_done_pulse got %b want 0", i, done); end
    end
  endtask

  task automatic test_stuck_saturate();
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    clear_bank();
    stuck = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      in_data = 4'b0001; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n_cmp++; if (j_out !== 4'b0001 || k_out !== 4'b0000) begin n_fail++; $display("FAIL stuck%0d_jk got %b/%b want 0001/0000", i, j_out, k_out); end
      step();
      if (CHK) step();
      n_cmp++; if (done !== 1'b1 || mismatch !== CHK) begin n_fail++; $display("FAIL stuck%0d_mismatch got done=%b mm=%b want 1/%b", i, done, mismatch, CHK); end
      n_cmp++; if (err_cnt !== (CHK ? exp_cnt[i] : 2'd0)) begin n_fail++; $display("FAIL stuck%0d_err_cnt got %0d want %0d", i, err_cnt, CHK ? exp_cnt[i] : 2'd0); end
      step();
      n_cmp++; if (mismatch !== 1'b0) begin n_fail++; $display("FAIL stuck%0d_mm_pulse got %b want 0", i, mismatch); end
    end
    stuck = 4'b0000;
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int dones = 0;
    int acc_cyc [2] = '{-1, -1};
    clear_bank();
    in_data = 4'b0011; in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 1) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_busy got %b want 0", in_ready); end
      end
      if (in_valid && in_ready) begin
        acc_cyc[accepts] = c;
        accepts++;
      end
      step();
      if (accepts == 1 && acc_cyc[0] == c) begin
        n_cmp++; if (j_out !== 4'b0011 || k_out !== 4'b0000) begin n_fail++; $display("FAIL b2b_first_jk got %b/%b want 0011/0000", j_out, k_out); end
        in_data = 4'b0101;
      end
      if (accepts == 2 && acc_cyc[1] == c) begin
        n_cmp++; if (j_out !== 4'b0100 || k_out !== 4'b0010) begin n_fail++; $display("FAIL b2b_second_jk got %b/%b want 0100/0010", j_out, k_out); end
        in_valid = 1'b0;
      end
      if (done) dones++;
    end
    n_cmp++; if (acc_cyc[1] !== (CHK ? 3 : 2)) begin n_fail++; $display("FAIL b2b_second_accept_cycle got %0d want %0d", acc_cyc[1], CHK ? 3 : 2); end
    n_cmp++; if (accepts !== 2 || dones !== 2) begin n_fail++; $display("FAIL b2b_counts got acc=%0d done=%0d want 2/2", accepts, dones); end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    clear_bank();
    in_data = 4'b1010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (j_out !== 4'b1010) begin n_fail++; $display("FAIL rstmid_drive_j got %b want 1010", j_out); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (j_out !== 4'b0000 || k_out !== 4'b0000) begin n_fail++; $display("FAIL rstmid_jk got %b/%b want 0000/0000", j_out, k_out); end
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got rdy=%b busy=%b want 1/0", in_ready, busy); end
    n_cmp++; if (err_cnt !== 2'd0) begin n_fail++; $display("FAIL rstmid_err_cnt got %0d want 0", err_cnt); end
    for (int c = 0; c < 4; c++) begin
      if (done) dones++;
      step();
    end
    n_cmp++; if (dones !== 0) begin n_fail++; $display("FAIL rstmid_no_done got %0d want 0", dones); end
    clear_bank();
    in_data = 4'b1010; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (j_out !== 4'b1010 || k_out !== 4'b0000) begin n_fail++; $display("FAIL rstmid_reaccept_jk got %b/%b want 1010/0000", j_out, k_out); end
    step();
    n_cmp++; if (done !== !CHK) begin n_fail++; $display("FAIL rstmid_done_after_drive got %b want %b", done, !CHK); end
    if (CHK) step();
    n_cmp++; if (done !== 1'b1 || mismatch !== 1'b0) begin n_fail++; $display("FAIL rstmid_final_done got %b/%b want 1/0", done, mismatch); end
    step();
  endtask

  initial begin
    test_reset();
    test_excite();
    test_stuck_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
